// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // A latency of 1 needs no down-count, but keep at least one counter bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency timer: loaded with LATENCY-1 on a grant, counts down to zero.
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CNT_W = lat_cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter that parks at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch (I) and load/store (D),
// D priority with a starvation guard for I, one transaction outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state_r, state_nx_s;
  owner_t              owner_r, owner_nx_s;
  logic [STARVE_W-1:0] starve_cnt_r;
  logic                lat_zero_s;
  logic                window_s;
  logic                done_s;
  logic                grant_i_s;
  logic                grant_d_s;

  mem_lat_counter #(.LATENCY(LATENCY)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (grant_i_s | grant_d_s),
    .zero (lat_zero_s)
  );

  // Grant window and arbitration; rst masks the Mealy grants so outputs drop at once.
  always_comb begin
    done_s    = (state_r == ST_WAIT) && lat_zero_s;
    window_s  = !rst && ((state_r == ST_IDLE) || done_s);
    grant_d_s = window_s && d_req && !(i_req && (starve_cnt_r == STARVE_LIM));
    grant_i_s = window_s && i_req && !grant_d_s;
  end

  // Next-state and ownership.
  always_comb begin
    state_nx_s = state_r;
    owner_nx_s = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_d_s || grant_i_s) begin
          state_nx_s = ST_WAIT;
          owner_nx_s = grant_d_s ? OWN_D : OWN_I;
        end else begin
          state_nx_s = ST_IDLE;
          owner_nx_s = OWN_NONE;
        end
      end
      ST_WAIT: begin
        if (grant_d_s || grant_i_s) begin
          state_nx_s = ST_WAIT;
          owner_nx_s = grant_d_s ? OWN_D : OWN_I;
        end else if (done_s) begin
          state_nx_s = ST_IDLE;
          owner_nx_s = OWN_NONE;
        end else begin
          state_nx_s = ST_WAIT;
          owner_nx_s = owner_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        owner_nx_s = OWN_NONE;
      end
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_NONE;
    end else begin
      state_r <= state_nx_s;
      owner_r <= owner_nx_s;
    end
  end

  // Count D wins while I waits; any cycle without i_req forgives the debt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (!i_req || grant_i_s) begin
      starve_cnt_r <= '0;
    end else if (grant_d_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Memory-side routing from the winner and completion steering back to the owner.
  always_comb begin
    i_gnt     = grant_i_s;
    d_gnt     = grant_d_s;
    mem_en    = grant_i_s | grant_d_s;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d_s) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_i_s) begin
      mem_addr  = i_addr;
    end else begin
      mem_we    = 1'b0;
    end
    i_valid = !rst && done_s && (owner_r == OWN_I);
    d_valid = !rst && done_s && (owner_r == OWN_D);
    i_rdata = i_valid ? mem_rdata : '0;
    d_rdata = d_valid ? mem_rdata : '0;
    busy    = !rst && (state_r == ST_WAIT);
  end

endmodule
